// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the data-memory stall bridge.
//   bridge_state_t : bridge FSM state encoding (IDLE, BUSY, DONE)
//   BUS_ERR_DATA   : load data returned when an access times out
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter bounding an external memory access.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset, clears the count
//   clr     : synchronous clear (wins over run)
//   run     : count one cycle, saturating at TIMEOUT
//   expired : high while the count equals TIMEOUT
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_stall_bridge.sv
// Multi-cycle bridge between the core's data port and a req/ack external memory.
// Stalls the core through cpu_enable until each load or store completes; a watchdog
// aborts accesses that never see ext_ack, returning BUS_ERR_DATA and setting bus_err.
//   clk, reset                       : clock, asynchronous active-low reset
//   enable_in / cpu_enable           : global run enable in, gated core enable out
//   mem_rd, mem_wr, mem_addr,
//   mem_writedata / mem_readdata     : core data port (readdata registered)
//   ext_req, ext_we, ext_addr,
//   ext_wdata (out), ext_rdata,
//   ext_ack (in)                     : external memory handshake
//   bus_err                          : sticky timeout flag
module mem_stall_bridge
    import mips_bus_pkg::*;
#(
    parameter int unsigned wordsize = 32,
    parameter int unsigned ABITS    = 16,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_in,
    output logic                cpu_enable,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [wordsize-1:0] mem_addr,
    input  logic [wordsize-1:0] mem_writedata,
    output logic [wordsize-1:0] mem_readdata,
    output logic                ext_req,
    output logic                ext_we,
    output logic [ABITS-1:0]    ext_addr,
    output logic [wordsize-1:0] ext_wdata,
    input  logic [wordsize-1:0] ext_rdata,
    input  logic                ext_ack,
    output logic                bus_err
);

    bridge_state_t state;
    logic          access;
    logic          launch;
    logic          wd_run;
    logic          wd_clr;
    logic          expired;
    logic          unused_addr_bits;

    assign access = (mem_rd | mem_wr) & enable_in;
    assign launch = (state == IDLE) & access;

    // Counting starts in the launch cycle so the count equals the BUSY cycle number;
    // the timeout decision is then made in BUSY cycle TIMEOUT and DONE follows next.
    assign wd_run = launch | (state == BUSY);
    assign wd_clr = ~wd_run;

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .run    (wd_run),
        .expired(expired)
    );

    always_comb begin
        cpu_enable = 1'b0;
        case (state)
            IDLE:    cpu_enable = enable_in & ~access;
            BUSY:    cpu_enable = 1'b0;
            DONE:    cpu_enable = enable_in;
            default: cpu_enable = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ext_req      <= 1'b0;
            ext_we       <= 1'b0;
            ext_addr     <= '0;
            ext_wdata    <= '0;
            mem_readdata <= '0;
            bus_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        ext_addr  <= mem_addr[ABITS+1:2];
                        ext_wdata <= mem_writedata;
                        ext_we    <= mem_wr;  // rd and wr together counts as a store
                        ext_req   <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the expiry cycle still counts as a good completion.
                    if (ext_ack) begin
                        ext_req <= 1'b0;
                        if (!ext_we) begin
                            mem_readdata <= ext_rdata;
                        end
                        state <= DONE;
                    end else if (expired) begin
                        ext_req      <= 1'b0;
                        mem_readdata <= wordsize'(BUS_ERR_DATA);
                        bus_err      <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // Never relaunch from here: the core has not yet retired the instruction.
                    if (enable_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign unused_addr_bits = ^{mem_addr[wordsize-1:ABITS+2], mem_addr[1:0]};

endmodule

// File: tb/tb_mem_stall_bridge.sv
module tb_mem_stall_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_in;
    logic        enable_in4;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [31:0] ext_rdata;
    logic        ext_ack;
    logic        ext_ack4;

    logic        cpu_enable, cpu_enable4;
    logic [31:0] mem_readdata, mem_readdata4;
    logic        ext_req, ext_req4;
    logic        ext_we, ext_we4;
    logic [15:0] ext_addr, ext_addr4;
    logic [31:0] ext_wdata, ext_wdata4;
    logic        bus_err, bus_err4;

    int n_cmp  = 0;
    int n_fail = 0;
    int req_count = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    mem_stall_bridge #(
        .wordsize(32),
        .ABITS   (16),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_in    (enable_in),
        .cpu_enable   (cpu_enable),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .ext_req      (ext_req),
        .ext_we       (ext_we),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_rdata    (ext_rdata),
        .ext_ack      (ext_ack),
        .bus_err      (bus_err)
    );

    // Short-timeout instance, only active while enable_in4 is high.
    mem_stall_bridge #(
        .wordsize(32),
        .ABITS   (16),
        .TIMEOUT (4)
    ) dut4 (
        .clk          (clk),
        .reset        (reset),
        .enable_in    (enable_in4),
        .cpu_enable   (cpu_enable4),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata4),
        .ext_req      (ext_req4),
        .ext_we       (ext_we4),
        .ext_addr     (ext_addr4),
        .ext_wdata    (ext_wdata4),
        .ext_rdata    (ext_rdata),
        .ext_ack      (ext_ack4),
        .bus_err      (bus_err4)
    );

    // Count rising edges of ext_req on the main instance.
    always @(posedge clk) begin
        req_prev <= ext_req;
        if (ext_req && !req_prev) req_count <= req_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", ext_req); end
        n_cmp++; if (ext_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", ext_we); end
        n_cmp++; if (ext_addr !== 16'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", ext_addr); end
        n_cmp++; if (ext_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", ext_wdata); end
        n_cmp++; if (mem_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", mem_readdata); end
        n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus_err); end
        n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL rst_en: got %b want 1", cpu_enable); end
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_load_fast();
        mem_rd = 1'b1; mem_addr = 32'h40; #1;
        n_cmp++; if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL ld_c0_en: got %b want 0", cpu_enable); end
        tick(); ext_ack = 1'b1; ext_rdata = 32'h12345678; #1;
        n_cmp++; if (ext_req !== 1'b1) begin n_fail++; $display("FAIL ld_c1_req: got %b want 1", ext_req); end
        n_cmp++; if (ext_addr !== 16'h0010) begin n_fail++; $display("FAIL ld_addr: got %h want 0010", ext_addr); end
        n_cmp++; if (ext_we !== 1'b0) begin n_fail++; $display("FAIL ld_we: got %b want 0", ext_we); end
        n_cmp++; if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL ld_c1_en: got %b want 0", cpu_enable); end
        tick(); ext_ack = 1'b0; #1;
        n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL ld_c2_en: got %b want 1", cpu_enable); end
        n_cmp++; if (mem_readdata !== 32'h12345678) begin n_fail++; $display("FAIL ld_data: got %h want 12345678", mem_readdata); end
        n_cmp++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL ld_c2_req: got %b want 0", ext_req); end
        tick(); mem_rd = 1'b0; #1;
        n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL ld_idle_en: got %b want 1", cpu_enable); end
    endtask

    task automatic test_store_delayed();
        mem_wr = 1'b1; mem_addr = 32'h8; mem_writedata = 32'hCAFEF00D; #1;
        n_cmp++; if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL st_c0_en: got %b want 0", cpu_enable); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) mem_writedata = 32'h0;
            if (k == 5) begin ext_ack = 1'b1; ext_rdata = 32'h55555555; end
            #1;
            n_cmp++; if (ext_req !== 1'b1) begin n_fail++; $display("FAIL st_req c%0d: got %b want 1", k, ext_req); end
            n_cmp++; if (ext_we !== 1'b1) begin n_fail++; $display("FAIL st_we c%0d: got %b want 1", k, ext_we); end
            n_cmp++; if (ext_addr !== 16'h2) begin n_fail++; $display("FAIL st_addr c%0d: got %h want 0002", k, ext_addr); end
            n_cmp++; if (ext_wdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL st_wdata c%0d: got %h want cafef00d", k, ext_wdata); end
            n_cmp++; if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL st_en c%0d: got %b want 0", k, cpu_enable); end
        end
        tick(); ext_ack = 1'b0; #1;
        n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL st_c6_en: got %b want 1", cpu_enable); end
        n_cmp++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL st_c6_req: got %b want 0", ext_req); end
        n_cmp++; if (mem_readdata !== 32'h12345678) begin n_fail++; $display("FAIL st_rdata: got %h want 12345678", mem_readdata); end
        tick(); mem_wr = 1'b0; #1;
    endtask

    task automatic test_rd_wr_both();
        mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'hC; mem_writedata = 32'h11112222;
        tick(); ext_ack = 1'b1; ext_rdata = 32'h99999999; #1;
        n_cmp++; if (ext_we !== 1'b1) begin n_fail++; $display("FAIL both_we: got %b want 1", ext_we); end
        n_cmp++; if (ext_addr !== 16'h3) begin n_fail++; $display("FAIL both_addr: got %h want 0003", ext_addr); end
        tick(); ext_ack = 1'b0; #1;
        n_cmp++; if (mem_readdata !== 32'h12345678) begin n_fail++; $display("FAIL both_rdata: got %h want 12345678", mem_readdata); end
        tick(); mem_rd = 1'b0; mem_wr = 1'b0; #1;
    endtask

    task automatic test_timeout();
        enable_in = 1'b0; enable_in4 = 1'b1; mem_rd = 1'b1; mem_addr = 32'h100; #1;
        n_cmp++; if (cpu_enable4 !== 1'b0) begin n_fail++; $display("FAIL to_c0_en: got %b want 0", cpu_enable4); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++; if (ext_req4 !== 1'b1) begin n_fail++; $display("FAIL to_req c%0d: got %b want 1", k, ext_req4); end
        end
        tick();
        n_cmp++; if (ext_req4 !== 1'b0) begin n_fail++; $display("FAIL to_c5_req: got %b want 0", ext_req4); end
        n_cmp++; if (mem_readdata4 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_data: got %h want deadbeef", mem_readdata4); end
        n_cmp++; if (bus_err4 !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", bus_err4); end
        n_cmp++; if (cpu_enable4 !== 1'b1) begin n_fail++; $display("FAIL to_c5_en: got %b want 1", cpu_enable4); end
        tick(); mem_rd = 1'b0;
        tick(); mem_rd = 1'b1; mem_addr = 32'h4;
        tick(); ext_ack4 = 1'b1; ext_rdata = 32'hA5A5A5A5;
        tick(); ext_ack4 = 1'b0; #1;
        n_cmp++; if (mem_readdata4 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL to_good_data: got %h want a5a5a5a5", mem_readdata4); end
        n_cmp++; if (bus_err4 !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", bus_err4); end
        n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL main_err: got %b want 0", bus_err); end
        tick(); mem_rd = 1'b0; enable_in4 = 1'b0; enable_in = 1'b1; #1;
    endtask

    task automatic test_enable_drop();
        int req_before;
        req_before = req_count;
        mem_rd = 1'b1; mem_addr = 32'h20;
        tick(); enable_in = 1'b0; #1;
        n_cmp++; if (ext_req !== 1'b1) begin n_fail++; $display("FAIL ed_req: got %b want 1", ext_req); end
        tick(); ext_ack = 1'b1; ext_rdata = 32'h13579BDF;
        tick(); ext_ack = 1'b0; #1;
        n_cmp++; if (mem_readdata !== 32'h13579BDF) begin n_fail++; $display("FAIL ed_data: got %h want 13579bdf", mem_readdata); end
        for (int k = 3; k <= 4; k++) begin
            n_cmp++; if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL ed_en c%0d: got %b want 0", k, cpu_enable); end
            n_cmp++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL ed_req c%0d: got %b want 0", k, ext_req); end
            tick();
        end
        enable_in = 1'b1; #1;
        n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL ed_c5_en: got %b want 1", cpu_enable); end
        tick(); mem_rd = 1'b0; #1;
        n_cmp++; if (req_count - req_before !== 1) begin n_fail++; $display("FAIL ed_reqs: got %0d want 1", req_count - req_before); end
    endtask

    task automatic test_reset_mid();
        mem_rd = 1'b1; mem_addr = 32'h44;
        tick();
        n_cmp++; if (ext_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_pre: got %b want 1", ext_req); end
        tick();
        #1 reset = 1'b0; #1;
        n_cmp++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b want 0", ext_req); end
        n_cmp++; if (ext_addr !== 16'h0) begin n_fail++; $display("FAIL rm_addr: got %h want 0", ext_addr); end
        n_cmp++; if (mem_readdata !== 32'h0) begin n_fail++; $display("FAIL rm_rdata: got %h want 0", mem_readdata); end
        n_cmp++; if (bus_err4 !== 1'b0) begin n_fail++; $display("FAIL rm_err4: got %b want 0", bus_err4); end
        mem_rd = 1'b0; #1;
        n_cmp++; if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL rm_en: got %b want 1", cpu_enable); end
        #1 reset = 1'b1;
        tick(); ext_ack = 1'b1; ext_rdata = 32'hFFFFFFFF;
        tick(); ext_ack = 1'b0; #1;
        n_cmp++; if (mem_readdata !== 32'h0) begin n_fail++; $display("FAIL rm_stray: got %h want 0", mem_readdata); end
        n_cmp++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_post: got %b want 0", ext_req); end
    endtask

    task automatic test_nonmem();
        logic [9:0] pat;
        pat = 10'b1011001101;
        for (int i = 0; i < 10; i++) begin
            tick();
            enable_in = pat[i]; mem_addr = $urandom; mem_writedata = $urandom; #1;
            n_cmp++; if (cpu_enable !== pat[i]) begin n_fail++; $display("FAIL nm_en i%0d: got %b want %b", i, cpu_enable, pat[i]); end
            n_cmp++; if (ext_req !== 1'b0) begin n_fail++; $display("FAIL nm_req i%0d: got %b want 0", i, ext_req); end
        end
        enable_in = 1'b1;
    endtask

    initial begin
        reset = 1'b0; enable_in = 1'b1; enable_in4 = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_writedata = '0;
        ext_rdata = '0; ext_ack = 1'b0; ext_ack4 = 1'b0;
        test_reset();
        test_load_fast();
        test_store_delayed();
        test_rd_wr_both();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        test_nonmem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
